// File: rtl/vdp_pkg.sv
// Shared encodings for the VDP CPU port: port selects, control-byte fields,
// status bit layout, interrupt-enable location and the VRAM handshake state.
// Pure definitions, no logic; imported by vdp_vram_req and vdp_cpu_port.
package vdp_pkg;

    // port_sel encodings (I/O port 0x80 / 0x81)
    localparam logic PORT_DATA = 1'b0;
    localparam logic PORT_CTRL = 1'b1;

    // Second control byte: bit7 selects register write, bit6 selects write setup
    localparam int CTRL_REG_WRITE_BIT   = 7;
    localparam int CTRL_WRITE_SETUP_BIT = 6;

    // Status register: frame (vblank) flag position
    localparam int STATUS_F_BIT = 7;

    // Interrupt enable lives in regs[1][5]
    localparam int IE_REG = 1;
    localparam int IE_BIT = 5;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_WAIT = 1'b1
    } vram_req_state_e;

endpackage

// File: rtl/vdp_vram_req.sv
// Single-outstanding VRAM request holder: captures an access on start, holds it until ack.
// Latency: start -> vram_req 1 clk; vram_req drops the clk after vram_ack.
// Backpressure: busy is high while a request is outstanding; start is ignored while busy.
//
// Ports: start/start_we/start_addr/start_wdata from the client; vram_* to the arbiter;
//        busy high from the clk after start until the clk after ack;
//        rd_done pulses in the ack cycle of a read (vram_rdata valid then).
module vdp_vram_req
    import vdp_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              start_we,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        start_wdata,
    output logic              vram_req,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    input  logic              vram_ack,
    output logic              busy,
    output logic              rd_done
);

    vram_req_state_e   state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= REQ_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_done = 1'b0;
        unique case (state_q)
            REQ_IDLE: begin
                if (start) begin
                    state_d = REQ_WAIT;
                    we_d    = start_we;
                    addr_d  = start_addr;
                    wdata_d = start_wdata;
                end
            end
            REQ_WAIT: begin
                if (vram_ack) begin
                    state_d = REQ_IDLE;
                    rd_done = ~we_q;
                end
            end
            default: state_d = REQ_IDLE;
        endcase
    end

    // Outputs come straight from flops so they are stable for the arbiter.
    assign vram_req   = (state_q == REQ_WAIT);
    assign busy       = (state_q == REQ_WAIT);
    assign vram_we    = we_q;
    assign vram_addr  = addr_q;
    assign vram_wdata = wdata_q;

endmodule

// File: rtl/vdp_cpu_port.sv
// TMS9918-style CPU port: register file, VRAM pointer, read-ahead buffer, status/IRQ.
// Latency: strobe -> vram_req 1 clk; read data lands in read_buf on the ack cycle.
// Backpressure: none toward the CPU; strobes during a pending VRAM op set sticky overrun and are dropped.
//
// Ports: wr_stb/rd_stb/port_sel/wdata/rdata = CPU side (0x80 data, 0x81 control);
//        vram_* = arbiter handshake; vblank_stb sets F; regs = flat register file;
//        int_n = ~(F & IE); busy = VRAM op pending; overrun = sticky dropped-strobe flag.
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int NUM_REGS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_stb,
    input  logic                  rd_stb,
    input  logic                  port_sel,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata,
    output logic                  vram_req,
    output logic                  vram_we,
    output logic [ADDR_W-1:0]     vram_addr,
    output logic [7:0]            vram_wdata,
    input  logic                  vram_ack,
    input  logic [7:0]            vram_rdata,
    input  logic                  vblank_stb,
    output logic [8*NUM_REGS-1:0] regs,
    output logic                  int_n,
    output logic                  busy,
    output logic                  overrun
);

    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        regs_d [NUM_REGS];
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        tmp_q, tmp_d;
    logic              flag_q, flag_d;
    logic [7:0]        read_buf_q, read_buf_d;
    logic              f_q, f_d;
    logic              overrun_q, overrun_d;

    logic              start;
    logic              start_we;
    logic [ADDR_W-1:0] start_addr;
    logic [7:0]        start_wdata;
    logic              rd_done;
    logic [7:0]        status;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            ptr_q      <= '0;
            tmp_q      <= '0;
            flag_q     <= 1'b0;
            read_buf_q <= '0;
            f_q        <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
            ptr_q      <= ptr_d;
            tmp_q      <= tmp_d;
            flag_q     <= flag_d;
            read_buf_q <= read_buf_d;
            f_q        <= f_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
        ptr_d       = ptr_q;
        tmp_d       = tmp_q;
        flag_d      = flag_q;
        read_buf_d  = read_buf_q;
        f_d         = f_q;
        overrun_d   = overrun_q;
        start       = 1'b0;
        start_we    = 1'b0;
        start_addr  = ptr_q;
        start_wdata = '0;

        if ((wr_stb || rd_stb) && busy) begin
            // Dropped entirely: only the sticky flag records it.
            overrun_d = 1'b1;
        end else if (wr_stb && port_sel == PORT_CTRL) begin
            if (!flag_q) begin
                tmp_d  = wdata;
                flag_d = 1'b1;
            end else begin
                flag_d = 1'b0;
                if (wdata[CTRL_REG_WRITE_BIT]) begin
                    // Out-of-range indices match no register and are ignored.
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (wdata[2:0] == 3'(i)) regs_d[i] = tmp_q;
                    end
                end else begin
                    ptr_d = ADDR_W'({wdata[5:0], tmp_q});
                    if (!wdata[CTRL_WRITE_SETUP_BIT]) begin
                        start      = 1'b1;
                        start_addr = ptr_d;
                    end
                end
            end
        end else if (wr_stb) begin
            start       = 1'b1;
            start_we    = 1'b1;
            start_addr  = ptr_q;
            start_wdata = wdata;
            read_buf_d  = wdata;
            ptr_d       = ptr_q + ADDR_W'(1);
            flag_d      = 1'b0;
        end else if (rd_stb && port_sel == PORT_DATA) begin
            // CPU already took read_buf; refill from the next address.
            flag_d     = 1'b0;
            ptr_d      = ptr_q + ADDR_W'(1);
            start      = 1'b1;
            start_addr = ptr_d;
        end else if (rd_stb) begin
            f_d    = 1'b0;
            flag_d = 1'b0;
        end

        if (rd_done) read_buf_d = vram_rdata;

        // Applied last so a vblank coinciding with a status read keeps F set.
        if (vblank_stb) f_d = 1'b1;
    end

    always_comb begin
        status               = '0;
        status[STATUS_F_BIT] = f_q;
    end

    vdp_vram_req #(
        .ADDR_W (ADDR_W)
    ) u_vram_req (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_we    (start_we),
        .start_addr  (start_addr),
        .start_wdata (start_wdata),
        .vram_req    (vram_req),
        .vram_we     (vram_we),
        .vram_addr   (vram_addr),
        .vram_wdata  (vram_wdata),
        .vram_ack    (vram_ack),
        .busy        (busy),
        .rd_done     (rd_done)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_flat
        assign regs[8*g +: 8] = regs_q[g];
    end

    assign rdata   = (port_sel == PORT_CTRL) ? status : read_buf_q;
    assign int_n   = ~(f_q & regs_q[IE_REG][IE_BIT]);
    assign overrun = overrun_q;

endmodule
